fifo_mem_ctrl: RTL

FIFO_MEM_CTRL -- requirements
Module: fifo_mem_ctrl

---
 rtl/fifo_mem_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_mem_ctrl.sv
// FIFO controller for a single-port synchronous RAM: one access per cycle, round-robin
// arbitration between push and pop, registered read data with a one-cycle valid pulse.
module fifo_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_LVL     = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LVL     = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic                  push_ack,
  output logic                  pop_ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf_err,
  output logic                  unf_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH:0]   AfLvl  = (ADDR_WIDTH + 1)'(AF_LVL);
  localparam logic [ADDR_WIDTH:0]   AeLvl  = (ADDR_WIDTH + 1)'(AE_LVL);
  localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CntOne = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  last_wr_q, last_wr_d;  // 1: write was granted last, read wins a tie
  logic                  rd_pend_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ovf_q, unf_q;

  logic wr_elig, rd_elig, wr_gnt, rd_gnt;

  assign full         = count_q[ADDR_WIDTH];
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfLvl);
  assign almost_empty = (count_q <= AeLvl);

  always_comb begin
    wr_elig = push & ~full;
    rd_elig = pop & ~empty;
    wr_gnt  = wr_elig & (~rd_elig | ~last_wr_q);
    rd_gnt  = rd_elig & (~wr_elig | last_wr_q);
  end

  always_comb begin
    push_ack  = wr_gnt;
    pop_ack   = rd_gnt;
    mem_we    = wr_gnt;
    mem_oe    = rd_gnt;
    mem_addr  = wr_gnt ? wr_ptr_q : rd_ptr_q;
    mem_wdata = wr_gnt ? data_in : '0;
    data_out  = data_q;
    valid_out = valid_q;
    ovf_err   = ovf_q;
    unf_err   = unf_q;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_wr_d = last_wr_q;
    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + PtrOne;
      count_d   = count_q + CntOne;
      last_wr_d = 1'b1;
    end else if (rd_gnt) begin
      rd_ptr_d  = rd_ptr_q + PtrOne;
      count_d   = count_q - CntOne;
      last_wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_wr_q <= 1'b1;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_wr_q <= last_wr_d;
      // RAM returns data the cycle after the grant; capture it then.
      rd_pend_q <= rd_gnt;
      valid_q   <= rd_pend_q;
      if (rd_pend_q) data_q <= mem_rdata;
      ovf_q     <= push & full;
      unf_q     <= pop & empty;
    end
  end

endmodule
